// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared word type, responder states, error data and byte-merge helper
package risc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE,
        ACCESS
    } ram_state_t;

    localparam word_t RAM_ERR_DATA = 32'hBAD1_BAD1;

    function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                         input logic [3:0] be);
        word_t merged;
        merged = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - RAM port bundle; ramsel exists only with RAM_BYTE_STROBE_EN
interface ram_responder_if;
    import risc_pkg::*;

    logic  Ren;
    logic  Wen;
    word_t ramaddr;
    word_t ramstore;
`ifdef RAM_BYTE_STROBE_EN
    logic [3:0] ramsel;
`endif
    word_t ramload;
    logic  busy_o;
    logic  err_o;

`ifdef RAM_BYTE_STROBE_EN
    modport master (output Ren, Wen, ramaddr, ramstore, ramsel,
                    input  ramload, busy_o, err_o);
    modport slave  (input  Ren, Wen, ramaddr, ramstore, ramsel,
                    output ramload, busy_o, err_o);
`else
    modport master (output Ren, Wen, ramaddr, ramstore,
                    input  ramload, busy_o, err_o);
    modport slave  (input  Ren, Wen, ramaddr, ramstore,
                    output ramload, busy_o, err_o);
`endif

endinterface

// File: rtl/ram_responder_ram_array.sv
// rtl/ram_responder_ram_array.sv - word storage with byte-enabled write, combinational read, async clear
module ram_array
    import risc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic [3:0]        wbe,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    word_t mem_q [DEPTH];
    word_t word_d;

    always_comb begin
        word_d = byte_merge(mem_q[waddr], wdata, wbe);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= word_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - single-outstanding RAM responder with LATENCY wait states; RAM_BYTE_STROBE_EN adds byte strobes
module ram_responder
    import risc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic          CLK,
    input  logic          RST,
    ram_responder_if.slave ramif
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    ram_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             data_q, data_d;
    logic [3:0]        sel_q, sel_d;
    logic              rd_q, rd_d;
    logic              oor_q, oor_d;
    logic              err_q, err_d;
    word_t             ramload_q, ramload_d;

    logic              req;
    logic              req_oor;
    logic [ADDR_W-1:0] req_idx;
    logic [3:0]        req_sel;
    logic [ADDR_W-1:0] rd_idx;
    word_t             rd_word;
    logic              mem_we;
    logic              busy;
    logic              err;
    logic              unused_addr_bits;

    assign req              = ramif.Ren | ramif.Wen;
    assign req_idx          = ramif.ramaddr[ADDR_W+1:2];
    assign req_oor          = (ramif.ramaddr >> (ADDR_W + 2)) != 32'd0;
    assign unused_addr_bits = ^ramif.ramaddr[1:0];

`ifdef RAM_BYTE_STROBE_EN
    assign req_sel = ramif.ramsel;
`else
    assign req_sel = 4'hF;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        oor_d     = oor_q;
        err_d     = err_q;
        ramload_d = ramload_q;
        rd_idx    = addr_q;
        busy      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                busy   = req;
                rd_idx = req_idx;
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    addr_d  = req_idx;
                    data_d  = ramif.ramstore;
                    sel_d   = req_sel;
                    rd_d    = ramif.Ren;
                    oor_d   = req_oor;
                    err_d   = req_oor | (ramif.Ren & ramif.Wen);
                    // With a single wait state the acceptance edge is also the data edge.
                    if (LATENCY == 1 && ramif.Ren) begin
                        ramload_d = req_oor ? RAM_ERR_DATA : rd_word;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    busy = 1'b1;
                    if (!req) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1 && rd_q) begin
                            ramload_d = oor_q ? RAM_ERR_DATA : rd_word;
                        end
                    end
                end else begin
                    // Final cycle: completion is reported and the write lands on the way out.
                    err     = err_q;
                    mem_we  = !rd_q && !oor_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= 4'd0;
            rd_q      <= 1'b0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            ramload_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            oor_q     <= oor_d;
            err_q     <= err_d;
            ramload_q <= ramload_d;
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .rst   (RST),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (data_q),
        .wbe   (sel_q),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    assign ramif.ramload = ramload_q;
    assign ramif.busy_o  = busy;
    assign ramif.err_o   = err;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed bench for ram_responder (ADDR_W=10, LATENCY=2), RAM_BYTE_STROBE_EN aware
module tb_ram_responder;

    logic clk;
    logic rst;

    ram_responder_if bus ();

    ram_responder #(
        .ADDR_W  (10),
        .LATENCY (2)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .ramif (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          nb;
    logic [31:0] ld;
    logic        er;
    logic [5:0]  seq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request, holds it until busy_o is seen low, then drops it.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, output int nbusy,
                              output logic [31:0] load, output logic eflag);
        nbusy = 0;
        @(posedge clk);
        #1;
        bus.Ren      = rd;
        bus.Wen      = wr;
        bus.ramaddr  = addr;
        bus.ramstore = data;
        @(negedge clk);
        while (bus.busy_o === 1'b1 && nbusy < 20) begin
            nbusy++;
            @(negedge clk);
        end
        load    = bus.ramload;
        eflag   = bus.err_o;
        bus.Ren = 1'b0;
        bus.Wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.Ren      = 1'b0;
        bus.Wen      = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
`ifdef RAM_BYTE_STROBE_EN
        bus.ramsel   = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_val("reset_busy", 32'(bus.busy_o), 32'd0);
        check_val("reset_ramload", bus.ramload, 32'h0);
        check_val("reset_err", 32'(bus.err_o), 32'd0);

        run_access(1'b1, 1'b0, 32'h10, 32'h0, nb, ld, er);
        check_val("rd10_busy_cycles", 32'(nb), 32'd2);
        check_val("rd10_data", ld, 32'h0);
        check_val("rd10_err", 32'(er), 32'd0);

        run_access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, nb, ld, er);
        check_val("wr40_busy_cycles", 32'(nb), 32'd2);
        check_val("wr40_err", 32'(er), 32'd0);

        run_access(1'b1, 1'b0, 32'h40, 32'h0, nb, ld, er);
        check_val("rd40_busy_cycles", 32'(nb), 32'd2);
        check_val("rd40_data", ld, 32'hDEADBEEF);

        repeat (2) @(negedge clk);
        check_val("ramload_holds", bus.ramload, 32'hDEADBEEF);

        // Aborted write: Wen dropped in cycle 1.
        @(posedge clk);
        #1;
        bus.Wen      = 1'b1;
        bus.ramaddr  = 32'h44;
        bus.ramstore = 32'hCAFEF00D;
        @(negedge clk);
        check_val("abort_wr_busy_c0", 32'(bus.busy_o), 32'd1);
        @(posedge clk);
        #1;
        bus.Wen = 1'b0;
        @(negedge clk);
        check_val("abort_wr_busy_c1", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        check_val("abort_wr_busy_c2", 32'(bus.busy_o), 32'd0);
        check_val("abort_wr_err_c2", 32'(bus.err_o), 32'd0);

        run_access(1'b1, 1'b0, 32'h44, 32'h0, nb, ld, er);
        check_val("rd44_after_abort", ld, 32'h0);

        // Aborted read of 0x40 must not update ramload (currently 0).
        @(posedge clk);
        #1;
        bus.Ren     = 1'b1;
        bus.ramaddr = 32'h40;
        @(posedge clk);
        #1;
        bus.Ren = 1'b0;
        repeat (2) @(negedge clk);
        check_val("abort_rd_ramload", bus.ramload, 32'h0);

        run_access(1'b1, 1'b0, 32'h0001_0000, 32'h0, nb, ld, er);
        check_val("oor_rd_busy_cycles", 32'(nb), 32'd2);
        check_val("oor_rd_data", ld, 32'hBAD1BAD1);
        check_val("oor_rd_err", 32'(er), 32'd1);
        @(negedge clk);
        check_val("oor_err_clears", 32'(bus.err_o), 32'd0);

        // 0x0001_0040 aliases word 0x40 in its low bits; the write must be dropped.
        run_access(1'b0, 1'b1, 32'h0001_0040, 32'h55555555, nb, ld, er);
        check_val("oor_wr_err", 32'(er), 32'd1);
        run_access(1'b1, 1'b0, 32'h40, 32'h0, nb, ld, er);
        check_val("oor_wr_dropped", ld, 32'hDEADBEEF);

        run_access(1'b1, 1'b1, 32'h40, 32'h12345678, nb, ld, er);
        check_val("rw_both_data", ld, 32'hDEADBEEF);
        check_val("rw_both_err", 32'(er), 32'd1);
        run_access(1'b1, 1'b0, 32'h40, 32'h0, nb, ld, er);
        check_val("rw_both_no_write", ld, 32'hDEADBEEF);
        check_val("rd40_err_clean", 32'(er), 32'd0);

        // Request held across two accesses: busy pattern 1,1,0,1,1,0.
        seq = 6'd0;
        @(posedge clk);
        #1;
        bus.Ren     = 1'b1;
        bus.ramaddr = 32'h40;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seq = {seq[4:0], bus.busy_o};
        end
        bus.Ren = 1'b0;
        check_val("back_to_back_busy", 32'(seq), 32'h36);
        check_val("back_to_back_data", bus.ramload, 32'hDEADBEEF);

`ifdef RAM_BYTE_STROBE_EN
        bus.ramsel = 4'hF;
        run_access(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, nb, ld, er);
        bus.ramsel = 4'b0101;
        run_access(1'b0, 1'b1, 32'h8, 32'h11223344, nb, ld, er);
        bus.ramsel = 4'b0000;
        run_access(1'b0, 1'b1, 32'h8, 32'h00000000, nb, ld, er);
        check_val("strobe_zero_busy_cycles", 32'(nb), 32'd2);
        bus.ramsel = 4'hF;
        run_access(1'b1, 1'b0, 32'h8, 32'h0, nb, ld, er);
        check_val("strobe_merge", ld, 32'hFF22FF44);
`endif

        // Reset pulsed in cycle 1 of a write.
        @(posedge clk);
        #1;
        bus.Wen      = 1'b1;
        bus.ramaddr  = 32'hC;
        bus.ramstore = 32'h12345678;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_busy_follows", 32'(bus.busy_o), 32'd1);
        check_val("rst_mid_err", 32'(bus.err_o), 32'd0);
        check_val("rst_mid_ramload", bus.ramload, 32'h0);
        bus.Wen = 1'b0;
        #1;
        check_val("rst_mid_busy_low", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_access(1'b1, 1'b0, 32'hC, 32'h0, nb, ld, er);
        check_val("rdC_after_rst", ld, 32'h0);
        check_val("rdC_err", 32'(er), 32'd0);
        run_access(1'b1, 1'b0, 32'h40, 32'h0, nb, ld, er);
        check_val("rd40_cleared", ld, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the memory controller's RAM port. It accepts a single outstanding read or write (`Ren`/`Wen`, `ramaddr`, `ramstore`), holds `busy_o` high for a parameterised number of wait states, then returns `ramload` or commits the write. It serves as the on-chip RAM model behind the memory controller in simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; depth is 2^ADDR_W words.
- `LATENCY`, 2: access cycles after acceptance; legal values are 1 to 15.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `Ren`  in  1  read request; held until `busy_o` is seen low.
- `Wen`  in  1  write request; held until `busy_o` is seen low.
- `ramaddr`  in  32  byte address; bits [1:0] are ignored.
- `ramstore`  in  32  write data.
- `ramsel`  in  4  byte strobes; present only with `RAM_BYTE_STROBE_EN`.
- `ramload`  out  32  read data, registered.
- `busy_o`  out  1  access in progress; low signals completion.
- `err_o`  out  1  error flag, valid in the completion cycle.

## Operation
- States (`ram_state_t`): IDLE and ACCESS.
- IDLE:
  - `busy_o = Ren | Wen`, combinational.
  - On a clock edge with `Ren | Wen` high: capture address, data, strobes and op; load `cnt = LATENCY-1`; go to ACCESS.
- ACCESS:
  - `busy_o = (cnt != 0)`.
  - Each edge with `cnt != 0`: decrement `cnt`.
  - Read: on the edge that makes `cnt` 0, load `ramload = mem[addr]`.
  - Write: commit `mem[addr]` on the edge leaving the final cycle (the cycle with `cnt == 0`).
  - After the final cycle, return to IDLE.
- Requests during ACCESS are not re-sampled. Address/data changes are ignored; the captured copies are used.
- Abort: if `Ren` and `Wen` are both low during any ACCESS cycle before the final one, go to IDLE on the next edge with no write and no `ramload` update.
- `Ren & Wen` together: perform a read and drop the write. `err_o = 1` in the completion cycle.
- Out of range: `ramaddr[31:ADDR_W+2]` nonzero.
  - Read loads `RAM_ERR_DATA` (32'hBAD1_BAD1).
  - Write is dropped.
  - `err_o = 1` in the completion cycle.
- `ramload` holds its last read value between accesses.
- `err_o` is 0 outside the completion cycle.

## Timing
- Request first seen in cycle 0. Completion cycle (`busy_o = 0`, data valid) is cycle LATENCY.
  - Example, LATENCY=2: cycles 0 and 1 busy, cycle 2 ready.
- If a request is still asserted in cycle LATENCY+1, it starts a new access.
  - Back-to-back accesses therefore cost LATENCY+1 cycles each.
- Reset values:
  - state IDLE, `cnt` 0.
  - `ramload` 32'h0, `err_o` 0.
  - all memory words 32'h0.
  - `busy_o` follows `Ren|Wen`.
- Reset asserted mid-access: abort immediately with no write; outputs take their reset values.

## Configuration
- `RAM_BYTE_STROBE_EN` defined:
  - The `ramsel` port exists.
  - A write updates only bytes whose `ramsel[i]` = 1, where byte i is bits [8i+7:8i].
  - `ramsel` = 4'b0000 makes a write complete normally with no change.
- Not defined:
  - No `ramsel` port.
  - Every write replaces the full word.

## Structure
- Shared in `risc_pkg`: `word_t`, `ram_state_t`, `RAM_ERR_DATA`.
- One sub-module, `ram_array`:
  - Synchronous storage with a write port and per-byte write enable (all ones when the macro is off).
  - Read is combinational by index.
  - Asynchronous clear on `RST`.

## Test plan
- Reset, then idle with `Ren`/`Wen` = 0 → `busy_o` 0, `ramload` 0, `err_o` 0. Read 0x10 → 32'h0.
- LATENCY=2: write 32'hDEADBEEF to 0x40, then read 0x40 → `busy_o` 1,1,0 for each access, `ramload` = 32'hDEADBEEF in cycle 2 of the read.
- Write 0x44 issued, `Wen` dropped in cycle 1 → `busy_o` 0 in cycle 2, state IDLE. Read 0x44 → 32'h0.
- Read 0x0001_0000 with ADDR_W=10 → `ramload` = 32'hBAD1BAD1, `err_o` 1 in the completion cycle. A write to the same address leaves all words unchanged.
- `RAM_BYTE_STROBE_EN`: write 32'hFFFFFFFF to 0x8, then 32'h11223344 with `ramsel` = 4'b0101 → read returns 32'hFF22FF44.
- `RST` pulsed in cycle 1 of a write of 32'h12345678 to 0xC → read 0xC returns 32'h0, `busy_o` follows request, `err_o` 0.
